// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage feeding the single-cycle datapath. Owns the PC,
//   fetches one instruction word per req/ack handshake, presents it with its
//   PC to the datapath, retires it when not stalled and freezes on the halt
//   opcode (instr[31:26] == 6'b111111).
//
//   Ports:
//     clk          clock, all state on the rising edge
//     rstn         asynchronous active-low reset
//     next_pc      next instruction address from the datapath (instr_addr)
//     stall        hold the current instruction in EXEC (no retire)
//     imem_req     instruction memory read request
//     imem_addr    instruction memory word address (the PC register)
//     imem_ack     read data valid on imem_rdata
//     imem_rdata   instruction word from memory
//     instr        registered instruction to the datapath
//     pc_address   PC of instr (the PC register)
//     instr_valid  instr/pc_address valid, datapath executes this cycle
//     halted       halt opcode retired, core frozen
//     retired_cnt  retired-instruction count (FETCH_PERF_CNT_EN only)
//
//   Build option: define FETCH_PERF_CNT_EN to add the retired_cnt counter.
//   The datapath must gate regWrite/memWrite with instr_valid & ~stall.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned AWIDTH   = 10,
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [AWIDTH-1:0] next_pc,
  input  logic              stall,
  output logic              imem_req,
  output logic [AWIDTH-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DWIDTH-1:0] imem_rdata,
  output logic [DWIDTH-1:0] instr,
  output logic [AWIDTH-1:0] pc_address,
  output logic              instr_valid,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       retired_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_REQ  = 2'd1,
    ST_EXEC = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   pc_q, pc_d;
  logic [DWIDTH-1:0]   instr_q, instr_d;
  logic                halt_op;
  logic                retire;

  assign halt_op = (instr_q[DWIDTH-1 -: 6] == 6'b111111);
  assign retire  = (state_q == ST_EXEC) && !stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      ST_RST: state_d = ST_REQ;
      ST_REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          // The halt instruction keeps its own PC visible on pc_address,
          // so the PC is only advanced for non-halt retirements.
          if (halt_op) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = ST_REQ;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_RST;
      pc_q    <= AWIDTH'(RESET_PC);
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = pc_q;
  assign pc_address  = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == ST_EXEC);
  assign halted      = (state_q == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (retire) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign retired_cnt = cnt_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed self-checking bench for fetch_unit. Each scenario task drives the
//   memory handshake and datapath inputs cycle by cycle and compares outputs
//   one time unit after the rising edge against hand-computed values.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        rstn;
  logic [9:0]  next_pc;
  logic        stall;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [9:0]  pc_address;
  logic        instr_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [31:0] cnt_snap;
`endif

  int checks;
  int failures;

  fetch_unit #(
    .AWIDTH  (10),
    .DWIDTH  (32),
    .RESET_PC(0)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .next_pc    (next_pc),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .pc_address (pc_address),
    .instr_valid(instr_valid),
    .halted     (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .retired_cnt(retired_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in RST with rstn just released (cycle 0).
  task automatic do_reset();
    rstn       = 1'b0;
    stall      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    next_pc    = '0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rstn = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    checks++; if (imem_addr !== 10'd0) begin failures++; $display("FAIL rst_addr got=%0d exp=0", imem_addr); end
    checks++; if (pc_address !== 10'd0) begin failures++; $display("FAIL rst_pc got=%0d exp=0", pc_address); end
    checks++; if (instr !== 32'd0) begin failures++; $display("FAIL rst_instr got=%h exp=0", instr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%b exp=0", halted); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (retired_cnt !== 32'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", retired_cnt); end
`endif
    tick();
    rstn       = 1'b1;
    // ack while in RST must be ignored
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_c0_req got=%b exp=0", imem_req); end
    tick();
    imem_ack = 1'b0;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rst_c1_req got=%b exp=1", imem_req); end
    checks++; if (instr !== 32'd0) begin failures++; $display("FAIL rst_ack_ignored got=%h exp=0", instr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_c1_valid got=%b exp=0", instr_valid); end
  endtask

  task automatic test_zero_wait();
    do_reset();
    imem_ack   = 1'b1;
    imem_rdata = 32'h2008_0005;
    next_pc    = 10'd1;
    tick();
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL zw_c1_req got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== 10'd0) begin failures++; $display("FAIL zw_c1_addr got=%0d exp=0", imem_addr); end
    tick();
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL zw_c2_valid got=%b exp=1", instr_valid); end
    checks++; if (instr !== 32'h2008_0005) begin failures++; $display("FAIL zw_c2_instr got=%h exp=20080005", instr); end
    checks++; if (pc_address !== 10'd0) begin failures++; $display("FAIL zw_c2_pc got=%0d exp=0", pc_address); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL zw_c2_req got=%b exp=0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL zw_c3_req got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== 10'd1) begin failures++; $display("FAIL zw_c3_addr got=%0d exp=1", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL zw_c3_valid got=%b exp=0", instr_valid); end
  endtask

  task automatic test_wait_states();
    int valid_seen;
    do_reset();
    imem_rdata = 32'h0000_1111;
    next_pc    = 10'd5;
    valid_seen = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin failures++; $display("FAIL ws_hold%0d req=%b addr=%0d exp req=1 addr=0", i, imem_req, imem_addr); end
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL ws_novalid%0d got=%b exp=0", i, instr_valid); end
      if (i == 3) imem_ack = 1'b1;
      tick();
    end
    imem_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (instr_valid === 1'b1) valid_seen++;
      tick();
    end
    checks++; if (valid_seen !== 1) begin failures++; $display("FAIL ws_valid_once got=%0d exp=1", valid_seen); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 10'd5) begin failures++; $display("FAIL ws_next req=%b addr=%0d exp req=1 addr=5", imem_req, imem_addr); end
  endtask

  task automatic test_stall();
    do_reset();
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0042;
    next_pc    = 10'd9;
    tick();
    tick();
    // in EXEC: ack with different data must not disturb instr
    imem_rdata = 32'h0BAD_0BAD;
    stall      = 1'b1;
`ifdef FETCH_PERF_CNT_EN
    cnt_snap = retired_cnt;
`endif
    for (int i = 0; i < 3; i++) begin
      if (i == 2) stall = 1'b0;
      checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL st_valid%0d got=%b exp=1", i, instr_valid); end
      checks++; if (pc_address !== 10'd0) begin failures++; $display("FAIL st_pc%0d got=%0d exp=0", i, pc_address); end
      checks++; if (instr !== 32'h0000_0042) begin failures++; $display("FAIL st_instr%0d got=%h exp=00000042", i, instr); end
      tick();
    end
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL st_after_valid got=%b exp=0", instr_valid); end
    checks++; if (imem_addr !== 10'd9) begin failures++; $display("FAIL st_after_addr got=%0d exp=9", imem_addr); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (retired_cnt !== cnt_snap + 32'd1) begin failures++; $display("FAIL st_cnt got=%0d exp=%0d", retired_cnt, cnt_snap + 32'd1); end
`endif
  endtask

  task automatic test_branch();
    do_reset();
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0000;
    next_pc    = 10'd7;
    tick(); tick(); tick();
    checks++; if (imem_addr !== 10'd7) begin failures++; $display("FAIL br_addr7 got=%0d exp=7", imem_addr); end
    next_pc = 10'd40;
    tick();
    checks++; if (pc_address !== 10'd7) begin failures++; $display("FAIL br_pc7 got=%0d exp=7", pc_address); end
    tick();
    checks++; if (imem_addr !== 10'd40) begin failures++; $display("FAIL br_addr40 got=%0d exp=40", imem_addr); end
    next_pc = 10'd1023;
    tick(); tick();
    checks++; if (imem_addr !== 10'd1023) begin failures++; $display("FAIL br_addr1023 got=%0d exp=1023", imem_addr); end
    next_pc = 10'd0;
    tick();
    checks++; if (pc_address !== 10'd1023) begin failures++; $display("FAIL br_pc1023 got=%0d exp=1023", pc_address); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin failures++; $display("FAIL br_wrap req=%b addr=%0d exp req=1 addr=0", imem_req, imem_addr); end
    imem_ack = 1'b0;
  endtask

  task automatic test_halt();
    int req_seen;
    do_reset();
    imem_ack   = 1'b1;
    imem_rdata = 32'hFC00_0000;
    next_pc    = 10'd3;
    req_seen   = 0;
    tick(); tick();
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL ht_exec_valid got=%b exp=1", instr_valid); end
`ifdef FETCH_PERF_CNT_EN
    cnt_snap = retired_cnt;
`endif
    tick();
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL ht_halted got=%b exp=1", halted); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL ht_valid got=%b exp=0", instr_valid); end
    checks++; if (instr !== 32'hFC00_0000) begin failures++; $display("FAIL ht_instr got=%h exp=fc000000", instr); end
    checks++; if (pc_address !== 10'd0) begin failures++; $display("FAIL ht_pc got=%0d exp=0", pc_address); end
    for (int i = 0; i < 20; i++) begin
      if (imem_req !== 1'b0 || halted !== 1'b1) req_seen++;
      tick();
    end
    checks++; if (req_seen !== 0) begin failures++; $display("FAIL ht_frozen got=%0d bad cycles exp=0", req_seen); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (retired_cnt !== cnt_snap + 32'd1) begin failures++; $display("FAIL ht_cnt got=%0d exp=%0d", retired_cnt, cnt_snap + 32'd1); end
`endif
    imem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_req();
    do_reset();
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    next_pc    = 10'd12;
    tick(); tick();
    imem_ack = 1'b0;
    tick(); tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 10'd12) begin failures++; $display("FAIL rm_pre req=%b addr=%0d exp req=1 addr=12", imem_req, imem_addr); end
    rstn = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rm_async_req got=%b exp=0", imem_req); end
    checks++; if (imem_addr !== 10'd0) begin failures++; $display("FAIL rm_async_addr got=%0d exp=0", imem_addr); end
    checks++; if (instr !== 32'd0) begin failures++; $display("FAIL rm_async_instr got=%h exp=0", instr); end
    imem_ack = 1'b1;
    tick();
    rstn = 1'b1;
    tick();
    checks++; if (instr !== 32'd0) begin failures++; $display("FAIL rm_late_ack got=%h exp=0", instr); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin failures++; $display("FAIL rm_restart req=%b addr=%0d exp req=1 addr=0", imem_req, imem_addr); end
    imem_ack = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstn       = 1'b0;
    stall      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    next_pc    = '0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_branch();
    test_halt();
    test_reset_mid_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
